// File: rtl/div_req_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle divider, with response timeout.
// Optional: define DIV_ZERO_CHECK_EN to answer divide-by-zero locally without starting the divider.
`timescale 1ns/1ps
module div_req_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             req1_ready,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t           state_reg;
  logic             grant_reg;
  logic             rr_last_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             err_reg;

  logic             idle;
  logic             grant_next;
  logic             req_hs;
  logic             rsp_hs;
  logic [WIDTH-1:0] sel_dividend;
  logic [WIDTH-1:0] sel_divisor;

  // On a tie the requester that was not served last wins; a lone requester always wins.
  assign idle         = (state_reg == IDLE);
  assign grant_next   = (req0_valid && req1_valid) ? ~rr_last_reg : req1_valid;
  assign req0_ready   = idle && req0_valid && !grant_next;
  assign req1_ready   = idle && req1_valid && grant_next;
  assign req_hs       = req0_ready || req1_ready;
  assign sel_dividend = grant_next ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant_next ? req1_divisor  : req0_divisor;

  assign busy          = !idle;
  assign div_start     = (state_reg == ISSUE);
  assign div_dividend  = dividend_reg;
  assign div_divisor   = divisor_reg;
  assign rsp0_valid    = (state_reg == RESP) && !grant_reg;
  assign rsp1_valid    = (state_reg == RESP) && grant_reg;
  assign rsp_hs        = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign rsp_quotient  = quo_reg;
  assign rsp_remainder = rem_reg;
  assign rsp_err       = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= 1'b0;
      rr_last_reg  <= 1'b1;
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_hs) begin
            grant_reg    <= grant_next;
            dividend_reg <= sel_dividend;
            divisor_reg  <= sel_divisor;
`ifdef DIV_ZERO_CHECK_EN
            if (sel_divisor == '0) begin
              quo_reg   <= '1;
              rem_reg   <= sel_dividend;
              err_reg   <= 1'b1;
              state_reg <= RESP;
            end else begin
              state_reg <= ISSUE;
            end
`else
            state_reg <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= BUSY;
        end
        BUSY: begin
          // A done arriving on the final timeout cycle still wins over the abort.
          if (div_done) begin
            quo_reg   <= div_quotient;
            rem_reg   <= div_remainder;
            err_reg   <= 1'b0;
            state_reg <= RESP;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            quo_reg   <= '1;
            rem_reg   <= '0;
            err_reg   <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_hs) begin
            rr_last_reg <= grant_reg;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_req_arbiter.md
DIV_REQ_ARBITER -- requirements
Module: div_req_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand, quotient and remainder width in bits.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles spent in BUSY waiting for div_done.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operand pair.
REQ-006 reqN_dividend, reqN_divisor  input  WIDTH  (N=0,1) operands; sampled only on the reqN handshake.
REQ-007 reqN_ready  output  1  (N=0,1) arbiter accepts requester N this cycle.
REQ-008 rspN_valid  output  1  (N=0,1) result for requester N is available.
REQ-009 rspN_ready  input  1  (N=0,1) requester N consumes its result.
REQ-010 rsp_quotient, rsp_remainder  output  WIDTH  result, shared by both responders and qualified by rspN_valid.
REQ-011 rsp_err  output  1  result is invalid (timeout or divide-by-zero).
REQ-012 div_start  output  1  one-cycle start pulse to the shared divider.
REQ-013 div_dividend, div_divisor  output  WIDTH  registered operands to the divider.
REQ-014 div_done  input  1  divider completion pulse.
REQ-015 div_quotient, div_remainder  input  WIDTH  divider result, valid while div_done=1.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states are IDLE, ISSUE, BUSY and RESP; the state and all outputs are registered or decoded only from the registered state and the grant.
REQ-018 IDLE: if exactly one reqN_valid is high, that requester is granted; if both are high, the requester not served last (rr_last) is granted.
REQ-019 reqN_ready is high only in IDLE and only for the granted N, combinationally; on that handshake the operands and grant are latched and the next state is ISSUE.
REQ-020 ISSUE: div_start=1 for exactly one cycle with the latched operands on div_dividend/div_divisor; the timeout counter clears; the next state is BUSY.
REQ-021 div_dividend/div_divisor are held stable from ISSUE through the end of BUSY.
REQ-022 BUSY: on div_done=1, div_quotient/div_remainder are captured, rsp_err=0 and the next state is RESP.
REQ-023 BUSY: the counter increments each cycle; when it reaches TIMEOUT-1 without div_done, the request aborts with rsp_err=1, quotient={WIDTH{1}}, remainder=0, and the next state is RESP.
REQ-024 div_done in any state other than BUSY is ignored.
REQ-025 RESP: rspG_valid=1 for the granted G only, held with a stable result until rspG_ready=1.
REQ-026 On the RESP handshake, rr_last<=G and the next state is IDLE; a new grant is not possible before the following cycle.
REQ-027 A requester that lowers reqN_valid before its handshake loses nothing; no state change occurs.
REQ-028 Minimum latency, with an immediate divider done: handshake to rspG_valid is 3 cycles (ISSUE, BUSY, RESP).

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, rr_last=1 (requester 0 wins the first tie), counter=0, operands and result=0, rsp_err=0.
REQ-030 All outputs are 0 after reset; a request in flight is discarded and no rsp is generated.
REQ-031 After a mid-BUSY reset, a later div_done from the divider is ignored, per REQ-024.

Configuration
REQ-032 With macro DIV_ZERO_CHECK_EN defined, a granted request with divisor=0 skips ISSUE/BUSY and goes from IDLE straight to RESP with quotient={WIDTH{1}}, remainder=dividend, rsp_err=1, and no div_start.
REQ-033 Without DIV_ZERO_CHECK_EN, divisor=0 is forwarded to the divider like any other request.

Verification
REQ-034 req0 13/3 alone, divider model done 10 cycles after start -> one div_start, rsp0_valid with q=4, r=1, err=0.
REQ-035 req0 and req1 both valid from reset and held -> grant order 0,1,0,1; each rsp appears only on its own rspN_valid.
REQ-036 rsp1_ready held low 5 cycles in RESP -> rsp1_valid and result stable all 5 cycles; no new reqN_ready until after the handshake.
REQ-037 Divider model never asserts done, TIMEOUT=64 -> rsp_err=1, q=4'hF, r=0 after 64 BUSY cycles; the next request is served normally.
REQ-038 rst asserted in BUSY, then a stale div_done -> no rsp; IDLE; the next request is granted to 0 on a tie.
REQ-039 With DIV_ZERO_CHECK_EN, req1 7/0 -> no div_start, rsp1 q=4'hF, r=7, err=1; without the macro, div_start pulses once.
